serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial W-bit adder built around a single full-adder cell plus a carry flip-flop.
- Loads two operands on a start pulse and shifts them LSB-first through the cell, one bit per cycle.
- After W cycles it presents the registered sum and carry-out with a one-cycle done pulse.
- Sits downstream of the operand source and upstream of the magnitude comparator; trades area for latency against the ripple adder.

Parameters:
- W, 4, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  W  operand A; captured on the accepting edge.
- b  input  W  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  W  registered sum; holds until the next completion.
- cout  output  1  registered carry-out; holds until the next completion.

Behaviour:
- Reset: all of the following clear asynchronously to 0 while rst_n=0.
  - Outputs: busy, done, sum, cout.
  - Internal state: areg, breg, sreg, carry, cnt; state returns to IDLE.
- Reset mid-operation aborts the addition and discards partial results.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge: areg<=a, breg<=b, carry<=cin, cnt<=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (one bit per edge):
  - Compute s and c from the cell fed with areg[0], breg[0], carry.
  - sreg<={s, sreg[W-1:1]}; areg and breg shift right one bit (zero fill); carry<=c; cnt<=cnt+1.
  - When cnt==W-1 at an edge: go to DONE, sum<={s, sreg[W-1:1]}, cout<=c.
- DONE: done=1 for exactly this cycle, then return to IDLE.
- Timing: start accepted at edge E0 -> done high during the cycle after edge E0+W. Latency is W+1 cycles; throughput is one addition per W+2 cycles.
- start while busy=1 (SHIFT or DONE) is ignored; no queuing.
- start held high continuously: a new addition begins in the cycle after done, with a, b and cin sampled at that edge.
- Arithmetic is modulo 2^W with cout as bit W.
  - Example (W=4): all-ones + all-ones + cin=1 -> sum=4'hF, cout=1.
- sum and cout change only on the DONE transition; they are stable at all other times.
- cnt width is clog2(W).

Optional Feature:
- Macro: SERIAL_ADDER_CMP_EN.
- When defined:
  - Extra outputs gt (1) and eq (1), computed serially during SHIFT.
  - On accept: eq_r<=1, gt_r<=0.
  - Each SHIFT edge: eq_r<=eq_r & ~(a0^b0); gt_r<=(a0 & ~b0) | (~(a0^b0) & gt_r). Here a0=areg[0], b0=breg[0]; the higher bit overrides.
  - gt and eq update together with sum and cout on the DONE transition, and reset to 0.
  - Compares a against b only; cin is ignored.
- When not defined: the gt and eq ports and their logic are absent; adder behaviour is unchanged.

Decomposition:
- Package serial_adder_pkg holds:
  - the state typedef (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - the clog2-based count-width constant function.
- One sub-module: fa_cell, a combinational 1-bit full adder (inputs a, b, c; outputs s, co), instantiated once.

Test Plan (W=4):
- Reset: hold rst_n=0 for 3 cycles -> busy=0, done=0, sum=0, cout=0. Release, idle 5 cycles -> outputs unchanged.
- Basic add and timing: start with a=5, b=3, cin=0 -> done exactly 5 cycles after the accepting edge, sum=8, cout=0, busy high for 5 cycles.
- Overflow and carry-in:
  - a=15, b=1, cin=0 -> sum=0, cout=1.
  - a=0, b=0, cin=1 -> sum=1, cout=0.
  - a=15, b=15, cin=1 -> sum=15, cout=1.
- Busy protection: start a=2, b=2, cin=0, then pulse start with a=9, b=9 two cycles later -> result sum=4, cout=0, only one done pulse. Also confirm sum and cout are unchanged until done.
- Reset mid-operation: start a=7, b=7, cin=0, drop rst_n on the 2nd SHIFT cycle -> busy=0, sum=0, no done pulse. A new start with a=1, b=1, cin=0 -> sum=2 after 5 cycles.
- With SERIAL_ADDER_CMP_EN defined:
  - a=9, b=6 -> gt=1, eq=0.
  - a=6, b=9 -> gt=0, eq=0.
  - a=10, b=10 -> gt=0, eq=1, sum=4, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// the width function for the bit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // The counter runs 0..W-1, so clog2(W) bits suffice; keep at least one bit.
  function automatic int cnt_width(input int w);
    int r;
    r = $clog2(w);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic element of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder cell plus a carry flop, LSB first.
// Define SERIAL_ADDER_CMP_EN to add serial magnitude-compare outputs gt/eq.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADDER_CMP_EN
  ,
  output logic         gt,
  output logic         eq
`endif
);

  localparam int CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     areg_q, areg_d;
  logic [W-1:0]     breg_q, breg_d;
  logic [W-1:0]     sreg_q, sreg_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_CMP_EN
  logic             eq_r_q, eq_r_d, gt_r_q, gt_r_d;
  logic             eq_q, eq_d, gt_q, gt_d;
`endif

  fa_cell u_fa (
    .a  (areg_q[0]),
    .b  (breg_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // NOTE: every variable gets its hold value before the case, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    sreg_d  = sreg_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_CMP_EN
    eq_r_d  = eq_r_q;
    gt_r_d  = gt_r_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          areg_d  = a;
          breg_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_ADDER_CMP_EN
          eq_r_d  = 1'b1;
          gt_r_d  = 1'b0;
`endif
        end
      end
      SHIFT: begin
        sreg_d  = {fa_s, sreg_q[W-1:1]};
        areg_d  = {1'b0, areg_q[W-1:1]};
        breg_d  = {1'b0, breg_q[W-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef SERIAL_ADDER_CMP_EN
        // Later (more significant) bits override the verdict of earlier ones.
        eq_r_d  = eq_r_q & ~(areg_q[0] ^ breg_q[0]);
        gt_r_d  = (areg_q[0] & ~breg_q[0]) | (~(areg_q[0] ^ breg_q[0]) & gt_r_q);
`endif
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = sreg_d;
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_CMP_EN
          eq_d    = eq_r_d;
          gt_d    = gt_r_d;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values; all registers clear on reset so an aborted
  // addition leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      areg_q  <= '0;
      breg_q  <= '0;
      sreg_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_CMP_EN
      eq_r_q  <= 1'b0;
      gt_r_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      sreg_q  <= sreg_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_CMP_EN
      eq_r_q  <= eq_r_d;
      gt_r_q  <= gt_r_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_CMP_EN
  assign gt   = gt_q;
  assign eq   = eq_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed, table-driven bench for serial_adder (W=4), plus hand-written
// sequences for busy protection, mid-operation reset and back-to-back starts.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_CMP_EN
  logic         gt, eq;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_CMP_EN
    ,
    .gt    (gt),
    .eq    (eq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_gt;
    logic         exp_eq;
  } vec_t;

  vec_t tv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts one addition and watches up to 20 cycles for done. lat is the
  // cycle index (1 = cycle after the accepting edge) where done was seen,
  // or 0 on timeout; busy_cyc counts cycles with busy high up to done.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, bc, done_cnt, done_at;
    logic [W-1:0] sum_at_done;

    tv[0] = '{4'd5,  4'd3,  1'b0, 4'd8,  1'b0, 1'b1, 1'b0};
    tv[1] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b1, 1'b0};
    tv[2] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0, 1'b0, 1'b1};
    tv[3] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1};
    tv[4] = '{4'd9,  4'd6,  1'b0, 4'd15, 1'b0, 1'b1, 1'b0};
    tv[5] = '{4'd6,  4'd9,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0};
    tv[6] = '{4'd10, 4'd10, 1'b0, 4'd4,  1'b1, 1'b0, 1'b1};
    tv[7] = '{4'd12, 4'd7,  1'b1, 4'd4,  1'b1, 1'b1, 1'b0};

    // Reset held for three cycles, then five idle cycles.
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, cout, sum}, '0);
`ifdef SERIAL_ADDER_CMP_EN
    check("reset_cmp", {gt, eq}, '0);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", i), {busy, done, cout, sum}, '0);
    end

    for (int i = 0; i < 8; i++) begin
      run_add(tv[i].a, tv[i].b, tv[i].cin, lat, bc);
      check($sformatf("v%0d_latency", i), lat, 5);
      check($sformatf("v%0d_busy_cycles", i), bc, 5);
      check($sformatf("v%0d_sum", i), sum, tv[i].exp_sum);
      check($sformatf("v%0d_cout", i), cout, tv[i].exp_cout);
`ifdef SERIAL_ADDER_CMP_EN
      check($sformatf("v%0d_gt", i), gt, tv[i].exp_gt);
      check($sformatf("v%0d_eq", i), eq, tv[i].exp_eq);
`endif
      @(negedge clk);
      check($sformatf("v%0d_done_pulse_end", i), {busy, done}, 2'b00);
    end

    // Busy protection: a second start during SHIFT must be ignored, and
    // the previous result must hold until the new done.
    done_cnt = 0;
    done_at = 0;
    sum_at_done = '0;
    @(negedge clk);
    a = 4'd2; b = 4'd2; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin a = 4'd9; b = 4'd9; start = 1'b1; end
      if (k == 3) start = 1'b0;
      if (done) begin
        done_cnt++;
        done_at = k;
        sum_at_done = sum;
        check("busy_prot_cout", cout, 1'b0);
      end else if (done_cnt == 0) begin
        check($sformatf("busy_prot_hold_%0d", k), {cout, sum}, {tv[7].exp_cout, tv[7].exp_sum});
      end
    end
    check("busy_prot_done_count", done_cnt, 1);
    check("busy_prot_done_at", done_at, 5);
    check("busy_prot_sum", sum_at_done, 4'd4);
    check("busy_prot_sum_after", sum, 4'd4);

    // Reset during the second SHIFT cycle aborts with no done pulse.
    @(negedge clk);
    a = 4'd7; b = 4'd7; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {busy, done, cout, sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midreset_no_done", done_cnt, 0);
    check("midreset_busy", busy, 1'b0);
    run_add(4'd1, 4'd1, 1'b0, lat, bc);
    check("after_reset_latency", lat, 5);
    check("after_reset_sum", sum, 4'd2);
    check("after_reset_cout", cout, 1'b0);

    // start held high: next addition accepted at the edge ending the IDLE
    // cycle after done, giving one result every W+2 cycles.
    done_cnt = 0;
    done_at = 0;
    @(negedge clk);
    a = 4'd3; b = 4'd4; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_at = k;
        if (done_cnt == 1) begin
          check("b2b_first_sum", sum, 4'd7);
          a = 4'd1; b = 4'd1;
        end else begin
          start = 1'b0;
          check("b2b_second_sum", sum, 4'd2);
        end
      end
    end
    check("b2b_done_count", done_cnt, 2);
    check("b2b_second_done_at", done_at, 11);
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
